ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline.sv | 166 ++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Control-path pipeline for a classic 5-stage MIPS-style core. It carries the
// ID-stage control bundles through the ID/EX, EX/MEM and MEM/WB registers,
// detects load-use hazards (stall plus bubble), generates the IF/ID flush for
// taken branches and jumps, and selects EX operand forwarding.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            asynchronous active-low reset
//   WB_i             {RegWrite, MemtoReg} from ID
//   MEM_i            {MemWrite, MemRead} from ID
//   EX_i             {ALUSrc, ALUOp[1:0], RegDst} from ID
//   Rs_i/Rt_i/Rd_i   register fields of the instruction in ID
//   branch_taken_i   beq resolved taken in ID
//   jump_i           j in ID
//   stall_o          hold PC and IF/ID
//   ifid_flush_o     zero the IF/ID instruction
//   ex_*             EX-stage controls and destination register
//   ForwardA_o/B_o   EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   mem_*            MEM-stage controls and destination register
//   wb_*             WB-stage controls and destination register
module ctrl_pipeline #(
  parameter int RA_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      WB_i,
  input  logic [1:0]      MEM_i,
  input  logic [3:0]      EX_i,
  input  logic [RA_W-1:0] Rs_i,
  input  logic [RA_W-1:0] Rt_i,
  input  logic [RA_W-1:0] Rd_i,
  input  logic            branch_taken_i,
  input  logic            jump_i,
  output logic            stall_o,
  output logic            ifid_flush_o,
  output logic            ex_ALUSrc_o,
  output logic [1:0]      ex_ALUOp_o,
  output logic [RA_W-1:0] ex_WriteReg_o,
  output logic [1:0]      ForwardA_o,
  output logic [1:0]      ForwardB_o,
  output logic            mem_MemWrite_o,
  output logic            mem_MemRead_o,
  output logic [RA_W-1:0] mem_WriteReg_o,
  output logic            wb_RegWrite_o,
  output logic            wb_MemtoReg_o,
  output logic [RA_W-1:0] wb_WriteReg_o
);

  localparam logic [RA_W-1:0] REG_ZERO = {RA_W{1'b0}};

  // ID/EX stage
  logic [1:0]      idex_wb_r;
  logic [1:0]      idex_mem_r;
  logic [3:0]      idex_ex_r;
  logic [RA_W-1:0] idex_rs_r;
  logic [RA_W-1:0] idex_rt_r;
  logic [RA_W-1:0] idex_rd_r;
  // EX/MEM stage
  logic [1:0]      exmem_wb_r;
  logic [1:0]      exmem_mem_r;
  logic [RA_W-1:0] exmem_wr_r;
  // MEM/WB stage
  logic [1:0]      memwb_wb_r;
  logic [RA_W-1:0] memwb_wr_r;

  logic            stall_s;
  logic [RA_W-1:0] ex_write_reg_s;

  // Forward select for one EX operand. EX/MEM wins over MEM/WB because it
  // holds the younger result; register 0 is never a source.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            exmem_rw,
    input logic [RA_W-1:0] exmem_wr,
    input logic            memwb_rw,
    input logic [RA_W-1:0] memwb_wr
  );
    logic [1:0] sel;
    if (exmem_rw && (exmem_wr != REG_ZERO) && (exmem_wr == src)) begin
      sel = 2'b10;
    end else if (memwb_rw && (memwb_wr != REG_ZERO) && (memwb_wr == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Destination register mux: RegDst selects Rd (R-type) over Rt (I-type).
  always_comb begin
    if (idex_ex_r[0]) begin
      ex_write_reg_s = idex_rd_r;
    end else begin
      ex_write_reg_s = idex_rt_r;
    end
  end

  // Load-use hazard: the load in EX targets a register the ID instruction reads.
  always_comb begin
    if (idex_mem_r[0] && (idex_rt_r != REG_ZERO) &&
        ((idex_rt_r == Rs_i) || (idex_rt_r == Rt_i))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Stage registers; a stall loads a bubble into the ID/EX control fields only.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_wb_r   <= 2'b00;
      idex_mem_r  <= 2'b00;
      idex_ex_r   <= 4'b0000;
      idex_rs_r   <= REG_ZERO;
      idex_rt_r   <= REG_ZERO;
      idex_rd_r   <= REG_ZERO;
      exmem_wb_r  <= 2'b00;
      exmem_mem_r <= 2'b00;
      exmem_wr_r  <= REG_ZERO;
      memwb_wb_r  <= 2'b00;
      memwb_wr_r  <= REG_ZERO;
    end else begin
      if (stall_s) begin
        idex_wb_r  <= 2'b00;
        idex_mem_r <= 2'b00;
        idex_ex_r  <= 4'b0000;
      end else begin
        idex_wb_r  <= WB_i;
        idex_mem_r <= MEM_i;
        idex_ex_r  <= EX_i;
      end
      idex_rs_r   <= Rs_i;
      idex_rt_r   <= Rt_i;
      idex_rd_r   <= Rd_i;
      exmem_wb_r  <= idex_wb_r;
      exmem_mem_r <= idex_mem_r;
      exmem_wr_r  <= ex_write_reg_s;
      memwb_wb_r  <= exmem_wb_r;
      memwb_wr_r  <= exmem_wr_r;
    end
  end

  // Stall only follows ID/EX state, which reset clears, so it already reads 0
  // in reset. Flush depends on raw inputs and is gated by reset explicitly.
  assign stall_o      = stall_s;
  assign ifid_flush_o = rst_i & (branch_taken_i | jump_i) & ~stall_s;

  assign ex_ALUSrc_o   = idex_ex_r[3];
  assign ex_ALUOp_o    = idex_ex_r[2:1];
  assign ex_WriteReg_o = ex_write_reg_s;

  assign ForwardA_o = fwd_sel(idex_rs_r, exmem_wb_r[1], exmem_wr_r,
                              memwb_wb_r[1], memwb_wr_r);
  assign ForwardB_o = fwd_sel(idex_rt_r, exmem_wb_r[1], exmem_wr_r,
                              memwb_wb_r[1], memwb_wr_r);

  assign mem_MemWrite_o = exmem_mem_r[1];
  assign mem_MemRead_o  = exmem_mem_r[0];
  assign mem_WriteReg_o = exmem_wr_r;

  assign wb_RegWrite_o  = memwb_wb_r[1];
  assign wb_MemtoReg_o  = memwb_wb_r[0];
  assign wb_WriteReg_o  = memwb_wr_r;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline
// Directed-vector bench for ctrl_pipeline: reset state, R-type flow through all
// stages, load-use stall and bubble, EX/MEM and MEM/WB forwarding with priority,
// register-0 exclusion, jump flush versus stall, and asynchronous reset mid-stall.
module tb_ctrl_pipeline;

  localparam int RA_W = 5;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [1:0]      WB_i = 2'b00;
  logic [1:0]      MEM_i = 2'b00;
  logic [3:0]      EX_i = 4'b0000;
  logic [RA_W-1:0] Rs_i = 5'd0;
  logic [RA_W-1:0] Rt_i = 5'd0;
  logic [RA_W-1:0] Rd_i = 5'd0;
  logic            branch_taken_i = 1'b0;
  logic            jump_i = 1'b0;
  logic            stall_o;
  logic            ifid_flush_o;
  logic            ex_ALUSrc_o;
  logic [1:0]      ex_ALUOp_o;
  logic [RA_W-1:0] ex_WriteReg_o;
  logic [1:0]      ForwardA_o;
  logic [1:0]      ForwardB_o;
  logic            mem_MemWrite_o;
  logic            mem_MemRead_o;
  logic [RA_W-1:0] mem_WriteReg_o;
  logic            wb_RegWrite_o;
  logic            wb_MemtoReg_o;
  logic [RA_W-1:0] wb_WriteReg_o;

  int n_total = 0;
  int n_bad   = 0;

  ctrl_pipeline #(.RA_W(RA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .WB_i(WB_i), .MEM_i(MEM_i), .EX_i(EX_i),
    .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i),
    .branch_taken_i(branch_taken_i), .jump_i(jump_i),
    .stall_o(stall_o), .ifid_flush_o(ifid_flush_o),
    .ex_ALUSrc_o(ex_ALUSrc_o), .ex_ALUOp_o(ex_ALUOp_o), .ex_WriteReg_o(ex_WriteReg_o),
    .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
    .mem_MemWrite_o(mem_MemWrite_o), .mem_MemRead_o(mem_MemRead_o),
    .mem_WriteReg_o(mem_WriteReg_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_MemtoReg_o(wb_MemtoReg_o),
    .wb_WriteReg_o(wb_WriteReg_o)
  );

  always #5 clk_i = ~clk_i;

  // all outputs packed together, for the reset checks
  function automatic logic [31:0] all_outs();
    return {4'h0, stall_o, ifid_flush_o, ex_ALUSrc_o, ex_ALUOp_o, ex_WriteReg_o,
            ForwardA_o, ForwardB_o, mem_MemWrite_o, mem_MemRead_o, mem_WriteReg_o,
            wb_RegWrite_o, wb_MemtoReg_o, wb_WriteReg_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    WB_i = wb; MEM_i = mem; EX_i = ex; Rs_i = rs; Rt_i = rt; Rd_i = rd;
  endtask

  task automatic nop();
    drive(2'b00, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0);
    branch_taken_i = 1'b0;
    jump_i = 1'b0;
  endtask

  // advance one edge and settle off the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    chk("reset_outs", all_outs(), 32'h0);
    #10 rst_i = 1'b1;
    step();
    chk("idle_outs", all_outs(), 32'h0);

    // R-type: RegWrite, RegDst, ALUOp=10, Rd=3
    drive(2'b10, 2'b00, 4'b0101, 5'd1, 5'd2, 5'd3);
    step();
    chk("rt_ex_wr", {27'd0, ex_WriteReg_o}, 32'd3);
    chk("rt_ex_aluop", {30'd0, ex_ALUOp_o}, 32'd2);
    chk("rt_ex_alusrc", {31'd0, ex_ALUSrc_o}, 32'd0);
    nop();
    step();
    chk("rt_mem_wr", {27'd0, mem_WriteReg_o}, 32'd3);
    step();
    chk("rt_wb_rw", {31'd0, wb_RegWrite_o}, 32'd1);
    chk("rt_wb_wr", {27'd0, wb_WriteReg_o}, 32'd3);
    chk("rt_wb_m2r", {31'd0, wb_MemtoReg_o}, 32'd0);
    drain();

    // load-use: lw $5 then add reading $5
    drive(2'b11, 2'b01, 4'b1000, 5'd1, 5'd5, 5'd0);
    step();
    chk("lw_ex_wr", {27'd0, ex_WriteReg_o}, 32'd5);
    chk("lw_ex_alusrc", {31'd0, ex_ALUSrc_o}, 32'd1);
    drive(2'b10, 2'b00, 4'b0101, 5'd5, 5'd6, 5'd7);
    #1;
    chk("lu_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("lu_bubble_ctl", {29'd0, ex_ALUSrc_o, ex_ALUOp_o}, 32'd0);
    chk("lu_stall_clr", {31'd0, stall_o}, 32'd0);
    chk("lu_mem_rd", {31'd0, mem_MemRead_o}, 32'd1);
    chk("lu_mem_wr", {27'd0, mem_WriteReg_o}, 32'd5);
    step();
    chk("lu_add_wr", {27'd0, ex_WriteReg_o}, 32'd7);
    chk("lu_add_aluop", {30'd0, ex_ALUOp_o}, 32'd2);
    chk("lu_add_fwda", {30'd0, ForwardA_o}, 32'd1);
    chk("lu_add_stall", {31'd0, stall_o}, 32'd0);
    drain();

    // back-to-back dependency: EX/MEM forward
    drive(2'b10, 2'b00, 4'b0101, 5'd1, 5'd2, 5'd4);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd4, 5'd8, 5'd9);
    step();
    chk("fw_exmem_a", {30'd0, ForwardA_o}, 32'd2);
    chk("fw_exmem_b", {30'd0, ForwardB_o}, 32'd0);
    drain();

    // one independent instruction between: MEM/WB forward
    drive(2'b10, 2'b00, 4'b0101, 5'd1, 5'd2, 5'd4);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd1, 5'd2, 5'd10);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd4, 5'd8, 5'd9);
    step();
    chk("fw_memwb_a", {30'd0, ForwardA_o}, 32'd1);
    chk("fw_memwb_b", {30'd0, ForwardB_o}, 32'd0);
    drain();

    // two writers of $4 then reader of Rt=4: EX/MEM priority
    drive(2'b10, 2'b00, 4'b0101, 5'd1, 5'd2, 5'd4);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd2, 5'd3, 5'd4);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd1, 5'd4, 5'd11);
    step();
    chk("fw_prio_b", {30'd0, ForwardB_o}, 32'd2);
    chk("fw_prio_a", {30'd0, ForwardA_o}, 32'd0);
    drain();

    // writer to $0 never forwards
    drive(2'b10, 2'b00, 4'b0101, 5'd1, 5'd2, 5'd0);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd0, 5'd0, 5'd12);
    step();
    chk("fw_r0_b", {30'd0, ForwardB_o}, 32'd0);
    chk("fw_r0_a", {30'd0, ForwardA_o}, 32'd0);
    drain();

    // load of $0 never stalls
    drive(2'b11, 2'b01, 4'b1000, 5'd1, 5'd0, 5'd0);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd0, 5'd0, 5'd7);
    #1;
    chk("lu_r0_stall", {31'd0, stall_o}, 32'd0);
    drain();

    // jump without hazard flushes
    jump_i = 1'b1;
    #1;
    chk("jmp_flush", {31'd0, ifid_flush_o}, 32'd1);
    chk("jmp_nostall", {31'd0, stall_o}, 32'd0);
    step();
    nop();
    #1;
    chk("jmp_flush_off", {31'd0, ifid_flush_o}, 32'd0);
    branch_taken_i = 1'b1;
    #1;
    chk("br_flush", {31'd0, ifid_flush_o}, 32'd1);
    drain();

    // jump with load-use hazard: stall wins, flush follows after the bubble
    drive(2'b11, 2'b01, 4'b1000, 5'd1, 5'd5, 5'd0);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd5, 5'd6, 5'd7);
    jump_i = 1'b1;
    #1;
    chk("jst_flush", {31'd0, ifid_flush_o}, 32'd0);
    chk("jst_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("jst_flush_after", {31'd0, ifid_flush_o}, 32'd1);
    chk("jst_stall_after", {31'd0, stall_o}, 32'd0);
    drain();

    // asynchronous reset in the middle of a stall
    drive(2'b11, 2'b01, 4'b1000, 5'd1, 5'd5, 5'd0);
    step();
    drive(2'b10, 2'b00, 4'b0101, 5'd5, 5'd6, 5'd7);
    jump_i = 1'b1;
    #1;
    chk("ar_stall_pre", {31'd0, stall_o}, 32'd1);
    #1 rst_i = 1'b0;
    #1;
    chk("ar_outs", all_outs(), 32'h0);
    #1 rst_i = 1'b1;
    jump_i = 1'b0;
    step();
    chk("ar_capture_wr", {27'd0, ex_WriteReg_o}, 32'd7);
    chk("ar_capture_aluop", {30'd0, ex_ALUOp_o}, 32'd2);
    chk("ar_capture_stall", {31'd0, stall_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
